// File: rtl/cp0_ctrl_v2.sv
// CP0 beside the MEM stage: BadVAddr/Count/Compare/Status/Cause/EPC/PRId/Config,
// prescaled timer with sticky TI, interrupt masking, exception priority and redirect.
module cp0_ctrl_v2 #(
  parameter int unsigned COUNT_DIV  = 2,
  parameter int unsigned NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic [6:0]            exc_req_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delayslot_i,
  input  logic [31:0]           bad_addr_i,
  output logic [31:0]           data_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  exc_valid_o,
  output logic [4:0]            exc_code_o,
  output logic [31:0]           exc_target_o,
  output logic                  timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned     PS_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(COUNT_DIV - 1);

  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           epc_q, epc_d;
  logic [PS_W-1:0]       ps_q, ps_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [NUM_HW_INT-1:0] ip_hw_q;

  logic [5:0]  hw_ext;
  logic [7:0]  ip;
  logic [31:0] status_w;
  logic [31:0] cause_w;
  logic        int_req;
  logic        exc_taken;
  logic [4:0]  exc_code;
  logic        badv_fetch;
  logic        badv_data;

  // Hardware lines land on IP[2+k]; TI shares IP[7] with the top hardware line.
  assign hw_ext = 6'(ip_hw_q);
  always_comb begin
    ip    = {hw_ext, ip_sw_q};
    ip[7] = ip[7] | ti_q;
  end

  assign status_w = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_w  = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};
  assign int_req  = ie_q & ~exl_q & (|(ip & im_q));

  always_comb begin
    exc_taken  = 1'b1;
    exc_code   = EXC_INT;
    badv_fetch = 1'b0;
    badv_data  = 1'b0;
    if (int_req) begin
      exc_code = EXC_INT;
    end else if (exc_req_i[0]) begin
      exc_code   = EXC_ADEL;
      badv_fetch = 1'b1;
    end else if (exc_req_i[1]) begin
      exc_code = EXC_RI;
    end else if (exc_req_i[2]) begin
      exc_code = EXC_SYS;
    end else if (exc_req_i[3]) begin
      exc_code = EXC_BP;
    end else if (exc_req_i[4]) begin
      exc_code = EXC_OV;
    end else if (exc_req_i[5]) begin
      exc_code  = EXC_ADEL;
      badv_data = 1'b1;
    end else if (exc_req_i[6]) begin
      exc_code  = EXC_ADES;
      badv_data = 1'b1;
    end else begin
      exc_taken = 1'b0;
    end
  end

  assign exc_valid_o  = exc_taken | eret_i;
  assign exc_code_o   = exc_taken ? exc_code : 5'd0;
  assign exc_target_o = exc_taken ? EXC_VECTOR : (eret_i ? epc_q : 32'd0);
  assign status_o     = status_w;
  assign cause_o      = cause_w;
  assign epc_o        = epc_q;
  assign timer_int_o  = ti_q;

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_q;
      REG_COUNT:    data_o = count_q;
      REG_COMPARE:  data_o = compare_q;
      REG_STATUS:   data_o = status_w;
      REG_CAUSE:    data_o = cause_w;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID_VAL;
      REG_CONFIG:   data_o = 32'h0000_8000;
      default:      data_o = 32'd0;
    endcase
  end

  // Update order matters: mtc0, then ERET, then an exception overrides what it owns.
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    ps_d       = ps_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;

    if (we_i && waddr_i == REG_COUNT) begin
      count_d = data_i;
      ps_d    = '0;
    end else if (ps_q == PS_LAST) begin
      count_d = count_q + 32'd1;
      ps_d    = '0;
    end else begin
      ps_d = ps_q + PS_W'(1);
    end

    if (we_i && waddr_i == REG_COMPARE) begin
      compare_d = data_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q && compare_q != 32'd0) begin
      ti_d = 1'b1;
    end

    if (we_i) begin
      case (waddr_i)
        REG_STATUS: begin
          im_d  = data_i[15:8];
          exl_d = data_i[1];
          ie_d  = data_i[0];
        end
        REG_CAUSE: ip_sw_d = data_i[9:8];
        REG_EPC:   epc_d   = data_i;
        default: ;
      endcase
    end

    if (eret_i && !exc_taken) begin
      exl_d = 1'b0;
    end

    if (exc_taken) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        bd_d  = in_delayslot_i;
      end
      if (badv_fetch) begin
        badvaddr_d = pc_i;
      end else if (badv_data) begin
        badvaddr_d = bad_addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      ps_q       <= '0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
      ip_hw_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      ps_q       <= ps_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= int_i;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl_v2.sv
// Bench for cp0_ctrl_v2: constant vector table, hand sequences for timer and
// exception corner cases, then random traffic against a word-level model.
module tb_cp0_ctrl_v2;
  localparam int          DIV  = 2;
  localparam int          NHW  = 6;
  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] PRID = 32'h004C0102;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, we, eret, ds;
  logic [4:0]     waddr, raddr;
  logic [31:0]    wdata, pc, bad_addr;
  logic [NHW-1:0] int_in;
  logic [6:0]     exc_req;
  logic [31:0]    rdata, status, cause, epc, exc_target;
  logic           exc_valid, timer_int;
  logic [4:0]     exc_code;

  cp0_ctrl_v2 #(.COUNT_DIV(DIV), .NUM_HW_INT(NHW), .EXC_VECTOR(VEC), .PRID_VAL(PRID)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(wdata),
    .int_i(int_in), .exc_req_i(exc_req), .eret_i(eret), .pc_i(pc),
    .in_delayslot_i(ds), .bad_addr_i(bad_addr), .data_o(rdata), .status_o(status),
    .cause_o(cause), .epc_o(epc), .exc_valid_o(exc_valid), .exc_code_o(exc_code),
    .exc_target_o(exc_target), .timer_int_o(timer_int)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: Status and Cause kept as architectural words.
  logic [31:0]    m_count, m_compare, m_status, m_cause_base, m_epc, m_badv;
  int             m_ps;
  logic           m_ti;
  logic [NHW-1:0] m_hw;

  function automatic logic [31:0] m_cause_word();
    return m_cause_base | (32'(m_hw) << 10) | (m_ti ? 32'h4000_8000 : 32'd0);
  endfunction

  function automatic logic [4:0] code_of(input int t);
    case (t)
      0: return 5'd4;  1: return 5'd10; 2: return 5'd8;  3: return 5'd9;
      4: return 5'd12; 5: return 5'd4;  6: return 5'd5;  default: return 5'd0;
    endcase
  endfunction

  // -1 none, 7 interrupt, else the winning exc_req bit.
  function automatic int m_taken();
    logic [31:0] c;
    c = m_cause_word();
    if (m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'd0)) return 7;
    for (int i = 0; i < 7; i++) if (exc_req[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause_word();
      5'd14: return m_epc;
      5'd15: return PRID;
      5'd16: return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int   t;
    logic old_exl, set_ti;
    if (rst) begin
      m_count = 0; m_ps = 0; m_compare = 0; m_status = 32'h0040_0000;
      m_cause_base = 0; m_epc = 0; m_badv = 0; m_ti = 1'b0; m_hw = '0;
      return;
    end
    t       = m_taken();
    old_exl = m_status[1];
    set_ti  = (m_count == m_compare) && (m_compare != 32'd0);
    if (we && waddr == 5'd11) begin m_compare = wdata; m_ti = 1'b0; end
    else if (set_ti) m_ti = 1'b1;
    if (we && waddr == 5'd9) begin m_count = wdata; m_ps = 0; end
    else if (m_ps == DIV - 1) begin m_ps = 0; m_count = m_count + 32'd1; end
    else m_ps = m_ps + 1;
    m_hw = int_in;
    if (we && waddr == 5'd12) m_status = 32'h0040_0000 | (wdata & 32'h0000_FF03);
    if (we && waddr == 5'd13) m_cause_base = (m_cause_base & ~32'h300) | (wdata & 32'h300);
    if (we && waddr == 5'd14) m_epc = wdata;
    if (eret && t < 0) m_status = m_status & ~32'h2;
    if (t >= 0) begin
      m_cause_base = (m_cause_base & ~32'h7C) | (32'(code_of(t)) << 2);
      m_status     = m_status | 32'h2;
      if (!old_exl) begin
        m_epc = ds ? pc - 32'd4 : pc;
        m_cause_base = (m_cause_base & ~32'h8000_0000) | (ds ? 32'h8000_0000 : 32'd0);
      end
      if (t == 0) m_badv = pc;
      else if (t == 5 || t == 6) m_badv = bad_addr;
    end
  endtask

  task automatic check_all();
    int t;
    logic ev;
    logic [31:0] et;
    t  = m_taken();
    ev = (t >= 0) || eret;
    et = (t >= 0) ? VEC : (eret ? m_epc : 32'd0);
    chk("rnd_status", status, m_status);
    chk("rnd_cause", cause, m_cause_word());
    chk("rnd_epc", epc, m_epc);
    chk("rnd_valid", exc_valid, ev);
    chk("rnd_code", exc_code, code_of(t));
    chk("rnd_target", exc_target, et);
    chk("rnd_ti", timer_int, m_ti);
    chk("rnd_rdata", rdata, m_read(raddr));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; waddr = 0; wdata = 0; raddr = 0; int_in = '0;
    exc_req = 0; eret = 0; pc = 0; ds = 0; bad_addr = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[12];

  int regs[10] = '{8, 9, 11, 12, 13, 14, 15, 16, 3, 31};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 5'd12, 32'h0040FF03, "status_mask"};
    tbl[1]  = '{1'b1, 5'd12, 32'h00000000, 5'd12, 32'h00400000, "status_clear"};
    tbl[2]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 32'h00000300, "cause_mask"};
    tbl[3]  = '{1'b1, 5'd13, 32'h00000000, 5'd13, 32'h00000000, "cause_clear"};
    tbl[4]  = '{1'b1, 5'd14, 32'h12345678, 5'd14, 32'h12345678, "epc_rw"};
    tbl[5]  = '{1'b1, 5'd15, 32'h00000000, 5'd15, 32'h004C0102, "prid_ro"};
    tbl[6]  = '{1'b1, 5'd16, 32'h00000000, 5'd16, 32'h00008000, "config_ro"};
    tbl[7]  = '{1'b1, 5'd8,  32'h0000FFFF, 5'd8,  32'h00000000, "badv_ro"};
    tbl[8]  = '{1'b1, 5'd11, 32'h0000ABCD, 5'd11, 32'h0000ABCD, "compare_rw"};
    tbl[9]  = '{1'b0, 5'd0,  32'h00000000, 5'd3,  32'h00000000, "unmapped"};
    tbl[10] = '{1'b1, 5'd9,  32'h00000100, 5'd9,  32'h00000100, "count_load"};
    tbl[11] = '{1'b1, 5'd11, 32'h00000000, 5'd11, 32'h00000000, "compare_zero"};

    idle();
    rst = 1; cyc(); rst = 0; raddr = 5'd9; #1;
    chk("reset_status", status, 32'h0040_0000);
    chk("reset_cause", cause, 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_ti", timer_int, 1'b0);
    chk("reset_valid", exc_valid, 1'b0);
    chk("reset_count", rdata, 32'd0);

    // Count prescaling and wrap
    repeat (10) cyc();
    chk("count_10clk", rdata, 32'd5);
    we = 1; waddr = 5'd9; wdata = 32'hFFFFFFFF; cyc(); we = 0;
    repeat (2) cyc();
    chk("count_wrap", rdata, 32'd0);

    foreach (tbl[i]) begin
      we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      cyc();
      we = 0; raddr = tbl[i].raddr; #1;
      chk(tbl[i].name, rdata, tbl[i].exp);
    end

    // Timer interrupt through IM[7]/IE
    we = 1; waddr = 5'd11; wdata = 32'd8; cyc();
    waddr = 5'd9; wdata = 32'd0; cyc();
    waddr = 5'd12; wdata = 32'h0000_8001; cyc();
    we = 0; raddr = 5'd9;
    for (int k = 0; k < 40 && !timer_int; k++) cyc();
    chk("ti_set", timer_int, 1'b1);
    chk("ti_count", rdata, 32'd8);
    chk("ti_cause30", cause[30], 1'b1);
    chk("ti_valid", exc_valid, 1'b1);
    chk("ti_code", exc_code, 5'd0);
    chk("ti_target", exc_target, VEC);
    repeat (5) cyc();
    chk("ti_sticky", timer_int, 1'b1);
    chk("ti_masked_exl", exc_valid, 1'b0);
    we = 1; waddr = 5'd11; wdata = 32'd0; #1;
    chk("ti_before_clr", timer_int, 1'b1);
    cyc(); we = 0; #1;
    chk("ti_cleared", timer_int, 1'b0);
    we = 1; waddr = 5'd12; wdata = 32'd0; cyc(); we = 0;

    // RI beats Ov, delay-slot EPC
    exc_req = 7'b0010010; pc = 32'h100; ds = 1; #1;
    chk("ri_valid", exc_valid, 1'b1);
    chk("ri_code", exc_code, 5'd10);
    chk("ri_target", exc_target, VEC);
    cyc(); exc_req = 0; ds = 0; #1;
    chk("ri_epc", epc, 32'hFC);
    chk("ri_bd", cause[31], 1'b1);
    chk("ri_exl", status[1], 1'b1);
    chk("ri_exccode", cause[6:2], 5'd10);

    // Nested Sys keeps EPC
    exc_req = 7'b0000100; pc = 32'h200; #1;
    chk("sys_code", exc_code, 5'd8);
    cyc(); exc_req = 0; #1;
    chk("sys_exccode", cause[6:2], 5'd8);
    chk("sys_epc_kept", epc, 32'hFC);

    // ERET, then ERET losing to Ov
    we = 1; waddr = 5'd14; wdata = 32'h1234; cyc(); we = 0;
    eret = 1; #1;
    chk("eret_valid", exc_valid, 1'b1);
    chk("eret_target", exc_target, 32'h1234);
    chk("eret_code", exc_code, 5'd0);
    cyc(); eret = 0; #1;
    chk("eret_exl", status[1], 1'b0);
    eret = 1; exc_req = 7'b0010000; #1;
    chk("ov_code", exc_code, 5'd12);
    chk("ov_target", exc_target, VEC);
    cyc(); eret = 0; exc_req = 0; #1;
    chk("ov_exl", status[1], 1'b1);

    // AdES and BadVAddr, Status write mask
    exc_req = 7'b1000000; bad_addr = 32'h3; #1;
    chk("ades_code", exc_code, 5'd5);
    cyc(); exc_req = 0; raddr = 5'd8; #1;
    chk("ades_badv", rdata, 32'h3);
    we = 1; waddr = 5'd12; wdata = 32'hFFFFFFFF; cyc(); we = 0; #1;
    chk("status_all1", status, 32'h0040FF03);
    we = 1; wdata = 32'd0; cyc(); we = 0;

    // Exception beats same-cycle Status write on EXL only
    exc_req = 7'b0000100; we = 1; waddr = 5'd12; wdata = 32'h1; cyc();
    exc_req = 0; we = 0; #1;
    chk("exc_vs_mtc0", status, 32'h0040_0003);

    // Reset with a pending request
    exc_req = 7'b0000001; rst = 1; cyc(); rst = 0; exc_req = 0; #1;
    chk("midrst_status", status, 32'h0040_0000);
    chk("midrst_cause", cause, 32'd0);
    chk("midrst_valid", exc_valid, 1'b0);
    chk("midrst_epc", epc, 32'd0);

    repeat (600) begin
      rst      = ($urandom % 150) == 0;
      we       = ($urandom % 4) == 0;
      waddr    = 5'(regs[$urandom % 10]);
      raddr    = 5'(regs[$urandom % 10]);
      wdata    = $urandom;
      if (waddr == 5'd11) wdata = ($urandom % 5 == 0) ? 32'd0 : m_count + $urandom_range(0, 12);
      if (waddr == 5'd9)  wdata = ($urandom % 6 == 0) ? 32'hFFFFFFF0 : $urandom_range(0, 30);
      exc_req  = (($urandom % 6) == 0) ? 7'($urandom) : 7'd0;
      eret     = ($urandom % 8) == 0;
      int_in   = (($urandom % 4) == 0) ? NHW'($urandom) : '0;
      pc       = $urandom & 32'hFFFF_FFFC;
      ds       = $urandom % 2;
      bad_addr = $urandom;
      #1;
      check_all();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
